// File: rtl/dot_prod_feeder_if.sv
// Loader / dot_prod operand bus. The master is the loader and dot_prod side;
// the slave is the feeder that holds the operands.
interface dot_prod_feeder_if #(
  parameter int BITWIDTH       = 18,
  parameter int ADDR_BITWIDTH  = 4,
  parameter int LAYER_BITWIDTH = 288
);
  logic                      wrValid;
  logic                      wrReady;
  logic                      wrSel;
  logic [LAYER_BITWIDTH-1:0] wrData;
  logic                      wrLast;
  logic [ADDR_BITWIDTH-1:0]  colAddress;
  logic                      dataReady;
  logic [LAYER_BITWIDTH-1:0] weightRow;
  logic [BITWIDTH-1:0]       inputVector;
  logic                      computeEn;

  modport master (
    output wrValid, wrSel, wrData, wrLast, colAddress, dataReady,
    input  wrReady, weightRow, inputVector, computeEn
  );

  modport slave (
    input  wrValid, wrSel, wrData, wrLast, colAddress, dataReady,
    output wrReady, weightRow, inputVector, computeEn
  );
endinterface

// File: rtl/dot_prod_feeder.sv
// Operand server for dot_prod: column-major weight store plus a double-buffered
// input vector (active + shadow bank) that swaps on dataReady.
module dot_prod_feeder_col #(
  parameter int BITWIDTH       = 18,
  parameter int LAYER_BITWIDTH = 288
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w_we,
  input  logic [LAYER_BITWIDTH-1:0] w_din,
  input  logic                      v_we,
  input  logic                      v_bank,
  input  logic [BITWIDTH-1:0]       v_din,
  input  logic                      clr_we,
  input  logic                      clr_bank,
  output logic [LAYER_BITWIDTH-1:0] w_q,
  output logic [1:0][BITWIDTH-1:0]  v_q
);
  // Clear and write never target the same cycle: a vector write needs an
  // empty shadow, a swap needs a full one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q <= '0;
      v_q <= '0;
    end else begin
      if (w_we)   w_q <= w_din;
      if (clr_we) v_q[clr_bank] <= '0;
      if (v_we)   v_q[v_bank] <= v_din;
    end
  end
endmodule

module dot_prod_feeder #(
  parameter int NROW           = 16,
  parameter int NCOL           = 16,
  parameter int QN             = 6,
  parameter int QM             = 11,
  parameter int BITWIDTH       = QN + QM + 1,
  parameter int ADDR_BITWIDTH  = (NCOL > 1) ? $clog2(NCOL) : 1,
  parameter int LAYER_BITWIDTH = BITWIDTH * NROW
) (
  input  logic               clk,
  input  logic               reset,
  dot_prod_feeder_if.slave   bus
);
  localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);

  typedef enum logic {V_LOAD = 1'b0, V_FULL = 1'b1} vstate_t;

  vstate_t                                  vstate, vstate_nxt;
  logic [ADDR_BITWIDTH-1:0]                 w_ptr, v_ptr;
  logic                                     active_bank, weights_loaded, active_valid;
  logic                                     shadow_full, compute_en;
  logic                                     w_acc, v_acc, v_last, swap, drain;
  logic [NCOL-1:0][LAYER_BITWIDTH-1:0]      col_w;
  logic [NCOL-1:0][1:0][BITWIDTH-1:0]       col_v;

  assign shadow_full = (vstate == V_FULL);
  assign compute_en  = weights_loaded && active_valid;

  assign w_acc  = bus.wrValid &&  bus.wrSel && !compute_en;
  assign v_acc  = bus.wrValid && !bus.wrSel && !shadow_full;
  assign v_last = v_acc && ((v_ptr == LAST_COL) || bus.wrLast);

  // Swap whenever a full shadow exists and the active bank is free or consumed.
  assign swap  = shadow_full && (!active_valid || bus.dataReady);
  assign drain = bus.dataReady && active_valid && !shadow_full;

  assign bus.wrReady   = reset && (bus.wrSel ? !compute_en : !shadow_full);
  assign bus.computeEn = compute_en;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    dot_prod_feeder_col #(
      .BITWIDTH       (BITWIDTH),
      .LAYER_BITWIDTH (LAYER_BITWIDTH)
    ) u_col (
      .clk      (clk),
      .reset    (reset),
      .w_we     (w_acc && (w_ptr == ADDR_BITWIDTH'(c))),
      .w_din    (bus.wrData),
      .v_we     (v_acc && (v_ptr == ADDR_BITWIDTH'(c))),
      .v_bank   (~active_bank),
      .v_din    (bus.wrData[BITWIDTH-1:0]),
      .clr_we   (swap),
      .clr_bank (active_bank),
      .w_q      (col_w[c]),
      .v_q      (col_v[c])
    );
  end

  always_comb begin
    bus.weightRow   = '0;
    bus.inputVector = '0;
    if (int'(bus.colAddress) < NCOL) begin
      bus.weightRow   = col_w[bus.colAddress];
      bus.inputVector = col_v[bus.colAddress][active_bank];
    end
  end

  always_comb begin
    vstate_nxt = vstate;
    case (vstate)
      V_LOAD:  if (v_last) vstate_nxt = V_FULL;
      V_FULL:  if (swap)   vstate_nxt = V_LOAD;
      default: vstate_nxt = V_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vstate         <= V_LOAD;
      w_ptr          <= '0;
      v_ptr          <= '0;
      active_bank    <= 1'b0;
      weights_loaded <= 1'b0;
      active_valid   <= 1'b0;
    end else begin
      vstate <= vstate_nxt;
      if (w_acc) begin
        w_ptr <= (w_ptr == LAST_COL) ? '0 : w_ptr + ADDR_BITWIDTH'(1);
        if (w_ptr == LAST_COL) weights_loaded <= 1'b1;
      end
      if (v_acc) v_ptr <= v_last ? '0 : v_ptr + ADDR_BITWIDTH'(1);
      if (swap) begin
        active_bank  <= ~active_bank;
        active_valid <= 1'b1;
      end else if (drain) begin
        active_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/dot_prod_feeder.md
Name: dot_prod_feeder

Overview:
- Operand server for dot_prod. It is the responder side of the colAddress / weightRow / inputVector interface and the consumer of the dataReady pulse.
- Holds the weight matrix column-by-column, plus a double-buffered input vector (active bank + shadow bank). The next timestep's vector loads while the current one is being consumed.
- Sits between the host/sequence loader and dot_prod.

Parameters:
- NROW, 16, rows per weight column (outputs of dot_prod)
- NCOL, 16, columns / input vector length
- QN, 6, integer bits of fixed-point word
- QM, 11, fractional bits of fixed-point word
- BITWIDTH, QN+QM+1, word width (derived)
- ADDR_BITWIDTH, clog2(NCOL), column address width (derived)
- LAYER_BITWIDTH, BITWIDTH*NROW, weight column width (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- wrValid  in  1  loader word valid
- wrReady  out  1  loader word accepted when wrValid&&wrReady
- wrSel  in  1  0 = input vector element, 1 = weight column
- wrData  in  LAYER_BITWIDTH  weight column (element r at [r*BITWIDTH +: BITWIDTH]); vector element in [BITWIDTH-1:0]
- wrLast  in  1  last element of a vector load (ignored for wrSel=1)
- colAddress  in  ADDR_BITWIDTH  read column from dot_prod
- dataReady  in  1  dot_prod END pulse: active vector consumed
- weightRow  out  LAYER_BITWIDTH  weight column at colAddress
- inputVector  out  BITWIDTH  active-bank element at colAddress
- computeEn  out  1  weightsLoaded && activeValid; dot_prod is held in reset while low

Behaviour:
Reset (reset=0, async):
- Weight memory, both vector banks, wPtr, vPtr, activeBank, weightsLoaded, activeValid and shadowFull all clear to 0.
- Outputs: weightRow=0, inputVector=0, computeEn=0, wrReady=0.

Reads:
- Combinational, zero latency: weightRow = wmem[colAddress], inputVector = vbank[activeBank][colAddress].
- colAddress >= NCOL returns 0 on both outputs.

Weight load (wrSel=1):
- wrReady = !computeEn; weights may not change mid-compute.
- Each accepted word writes wmem[wPtr]; wPtr increments and wraps NCOL-1 -> 0.
- The wrap sets weightsLoaded=1 (sticky until reset).

Vector load (wrSel=0):
- wrReady = !shadowFull.
- Each accepted word writes vbank[!activeBank][vPtr]; vPtr increments.
- On vPtr==NCOL-1 or wrLast: shadowFull<=1 and vPtr<=0. Elements not written keep their cleared value of 0.
- Words arriving while shadowFull=1 stall; nothing is dropped.

Loader FSM (vector side):
- V_LOAD: accepting words. Moves to V_FULL on last word.
- V_FULL: wrReady=0. Moves to V_LOAD on swap.

Swap / consume, evaluated each cycle from registered state:
- activeValid=0 && shadowFull=1 -> swap.
- dataReady=1 && shadowFull=1 -> swap; activeValid stays 1 (back-to-back timesteps).
- dataReady=1 && shadowFull=0 -> activeValid<=0, so computeEn falls the next cycle.
- Swap action: activeBank<=!activeBank, activeValid<=1, shadowFull<=0. The old active bank, which becomes the new shadow, is cleared to 0 in the same edge.
- Final vector write coincident with dataReady: activeValid<=0 and shadowFull<=1 on that edge; the swap happens on the next edge (one-cycle computeEn gap).
- dataReady while activeValid=0 is ignored.

Other rules:
- No arithmetic; data is passed through bit-exact, signed Q(QN).(QM).
- A loader word with wrSel toggling mid-vector is legal. Weight and vector pointers are independent.

Test Plan:
- Reset mid-load: 5 vector words written, then reset low for 1 cycle -> all outputs 0, vPtr=0; the next load starts at element 0.
- Weight load: 16 columns, column c element r = c*16+r -> weightsLoaded=1; colAddress=3 gives weightRow element 5 = 53. computeEn stays 0 until a vector is loaded.
- First vector: elements 0x00800 (1.0) x16 -> swap the cycle after the 16th write; computeEn=1; inputVector=0x00800 at every address.
- Double buffer: second vector 0x3F800 (-1.0) loaded while active; a 17th word stalls (wrReady=0). Pulse dataReady -> inputVector=0x3F800 the next cycle, computeEn stays 1.
- Short vector: 4 words with wrLast on the 4th, then dataReady -> addresses 4..15 read 0. dataReady with no shadow pending -> computeEn=0 one cycle later.
- Collision: last vector word and dataReady in the same cycle -> computeEn low for exactly 1 cycle, then high with the new vector. A weight write attempted while computeEn=1 sees wrReady=0.
